lcd_nibble_writer: RTL and testbench

- Byte-to-HD44780 4-bit bus transmitter.
- Accepts command/data bytes from the badge text sequencer over a valid/ready handshake.
- Drives RS, E and dout[3:0] with parameterised setup, enable-pulse, gap and execution-wait timing.
- Sits directly between the character/command sequencer and the LCD output pins of the name badge top level.

---
 rtl/lcd_nibble_writer_if.sv | 21 ++
 rtl/lcd_nibble_writer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_nibble_writer_if.sv
// Byte handshake between the badge text sequencer and lcd_nibble_writer.
// The sequencer is the master: it offers din/rs_in/nibble_only with valid,
// and the writer answers with ready (idle) and busy (transfer in flight).
interface lcd_nibble_writer_if;
    logic [7:0] din;
    logic       rs_in;
    logic       nibble_only;
    logic       valid;
    logic       ready;
    logic       busy;

    modport master (
        output din, rs_in, nibble_only, valid,
        input  ready, busy
    );

    modport slave (
        input  din, rs_in, nibble_only, valid,
        output ready, busy
    );
endinterface

// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit bus transmitter for the name badge.
// A byte accepted from the sequencer is sent as high nibble then low nibble
// (or high nibble only when nibble_only is set) with configurable setup,
// enable-pulse, inter-nibble gap and execution-wait timing. Clear/home
// commands (RS=0, byte 0x01..0x03) get the long execution wait.
// Optional build macro LCD_AUTO_INIT_EN: after reset the block waits
// POWERON_WAIT_CYCLES, then plays the 4-bit init sequence on its own
// (nibbles 3,3,3,2 with long waits, then bytes 0x28,0x0C,0x01,0x06)
// before it first raises ready.
module lcd_nibble_writer #(
    parameter int SETUP_CYCLES     = 1,
    parameter int E_HIGH_CYCLES    = 2,
    parameter int GAP_CYCLES       = 1,
    parameter int CMD_WAIT_CYCLES  = 4,
    parameter int LONG_WAIT_CYCLES = 20,
    parameter int CNT_W            = 16
`ifdef LCD_AUTO_INIT_EN
    ,
    parameter int POWERON_WAIT_CYCLES = 50
`endif
) (
    input  logic                CLK,
    input  logic                RST,
    lcd_nibble_writer_if.slave  bus,
    output logic                RS,
    output logic                E,
    output logic [3:0]          dout
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP_H = 3'd1,
        ST_PULSE_H = 3'd2,
        ST_GAP     = 3'd3,
        ST_SETUP_L = 3'd4,
        ST_PULSE_L = 3'd5,
        ST_WAIT    = 3'd6,
        ST_POWERON = 3'd7   // only reachable with the auto-init build
    } state_t;

    // Terminal counter values: a state lasting N cycles leaves when cnt == N-1.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT_CYCLES - 1);

    // Clear display / return home need the long execution time; a lone
    // nibble never does (init nibbles ask for it explicitly).
    function automatic logic wants_long_wait(input logic [7:0] b,
                                             input logic       rs,
                                             input logic       nib);
        wants_long_wait = !nib && !rs &&
                          ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
    endfunction

`ifdef LCD_AUTO_INIT_EN
    localparam logic [CNT_W-1:0] PON_LAST  = CNT_W'(POWERON_WAIT_CYCLES - 1);
    localparam logic [2:0]       INIT_LAST = 3'd7;

    // Init ROM: {nibble_only, byte}; single nibbles travel in din[7:4].
    function automatic logic [8:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    init_rom = {1'b1, 8'h30};
            3'd1:    init_rom = {1'b1, 8'h30};
            3'd2:    init_rom = {1'b1, 8'h30};
            3'd3:    init_rom = {1'b1, 8'h20};
            3'd4:    init_rom = {1'b0, 8'h28};
            3'd5:    init_rom = {1'b0, 8'h0C};
            3'd6:    init_rom = {1'b0, 8'h01};
            3'd7:    init_rom = {1'b0, 8'h06};
            default: init_rom = {1'b0, 8'h06};
        endcase
    endfunction

    logic [2:0] init_idx_r, init_idx_s;
    logic       init_run_r, init_run_s;
`endif

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       byte_r, byte_s;
    logic             rs_r, rs_s;
    logic             nib_r, nib_s;
    logic             long_r, long_s;
    logic             ready_r, ready_s;
    logic             busy_r, busy_s;
    logic             rs_out_s;
    logic             e_s;
    logic [3:0]       dout_s;

    logic             load_s;
    logic [7:0]       load_byte_s;
    logic             load_rs_s;
    logic             load_nib_s;
    logic             load_long_s;

    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;

    // Next-state, transfer latching and next registered output values.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        load_s      = 1'b0;
        load_byte_s = bus.din;
        load_rs_s   = bus.rs_in;
        load_nib_s  = bus.nibble_only;
        load_long_s = wants_long_wait(bus.din, bus.rs_in, bus.nibble_only);
`ifdef LCD_AUTO_INIT_EN
        init_idx_s  = init_idx_r;
        init_run_s  = init_run_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (bus.valid) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_SETUP_H: begin
                if (cnt_r == SETUP_LAST) begin
                    state_s = ST_PULSE_H;
                end else begin
                    state_s = ST_SETUP_H;
                end
            end
            ST_PULSE_H: begin
                if (cnt_r == E_LAST) begin
                    state_s = nib_r ? ST_WAIT : ST_GAP;
                end else begin
                    state_s = ST_PULSE_H;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = ST_SETUP_L;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_SETUP_L: begin
                if (cnt_r == SETUP_LAST) begin
                    state_s = ST_PULSE_L;
                end else begin
                    state_s = ST_SETUP_L;
                end
            end
            ST_PULSE_L: begin
                if (cnt_r == E_LAST) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_PULSE_L;
                end
            end
            ST_WAIT: begin
                if (cnt_r == (long_r ? LONG_LAST : CMD_LAST)) begin
`ifdef LCD_AUTO_INIT_EN
                    if (init_run_r && (init_idx_r != INIT_LAST)) begin
                        init_idx_s                = init_idx_r + 3'd1;
                        load_s                    = 1'b1;
                        {load_nib_s, load_byte_s} = init_rom(init_idx_r + 3'd1);
                        load_rs_s                 = 1'b0;
                        load_long_s               = load_nib_s ||
                            wants_long_wait(load_byte_s, 1'b0, 1'b0);
                    end else begin
                        init_run_s = 1'b0;
                        state_s    = ST_IDLE;
                    end
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_WAIT;
                end
            end
`ifdef LCD_AUTO_INIT_EN
            ST_POWERON: begin
                if (cnt_r == PON_LAST) begin
                    init_idx_s                = 3'd0;
                    load_s                    = 1'b1;
                    {load_nib_s, load_byte_s} = init_rom(3'd0);
                    load_rs_s                 = 1'b0;
                    load_long_s               = 1'b1;
                end else begin
                    state_s = ST_POWERON;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (load_s) begin
            state_s = ST_SETUP_H;
            byte_s  = load_byte_s;
            rs_s    = load_rs_s;
            nib_s   = load_nib_s;
            long_s  = load_long_s;
        end else begin
            byte_s  = byte_r;
            rs_s    = rs_r;
            nib_s   = nib_r;
            long_s  = long_r;
        end

        // Every state entry restarts the counter; IDLE keeps it parked at 0.
        if ((state_s != state_r) || (state_s == ST_IDLE)) begin
            cnt_s = {CNT_W{1'b0}};
        end else begin
            cnt_s = cnt_s;
        end

        // Outputs follow the state being entered so they are registered.
        ready_s  = (state_s == ST_IDLE);
        busy_s   = (state_s != ST_IDLE);
        e_s      = (state_s == ST_PULSE_H) || (state_s == ST_PULSE_L);
        rs_out_s = RS;
        dout_s   = dout;
        if (state_s == ST_SETUP_H) begin
            rs_out_s = rs_s;
            dout_s   = byte_s[7:4];
        end else if (state_s == ST_SETUP_L) begin
            dout_s   = byte_s[3:0];
        end else begin
            dout_s   = dout;
        end
    end

    // State, latched transfer and registered pin/handshake outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
`ifdef LCD_AUTO_INIT_EN
            state_r    <= ST_POWERON;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
            init_idx_r <= 3'd0;
            init_run_r <= 1'b1;
`else
            state_r    <= ST_IDLE;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
`endif
            cnt_r      <= {CNT_W{1'b0}};
            byte_r     <= 8'h00;
            rs_r       <= 1'b0;
            nib_r      <= 1'b0;
            long_r     <= 1'b0;
            RS         <= 1'b0;
            E          <= 1'b0;
            dout       <= 4'h0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            byte_r     <= byte_s;
            rs_r       <= rs_s;
            nib_r      <= nib_s;
            long_r     <= long_s;
            ready_r    <= ready_s;
            busy_r     <= busy_s;
            RS         <= rs_out_s;
            E          <= e_s;
            dout       <= dout_s;
`ifdef LCD_AUTO_INIT_EN
            init_idx_r <= init_idx_s;
            init_run_r <= init_run_s;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Self-checking bench for lcd_nibble_writer with default timing parameters.
// A fixed vector table, randomized bytes against a timing/nibble model,
// and hand-written sequences for reset, back-to-back and auto-init.
module tb_lcd_nibble_writer;

    localparam int S_C = 1;
    localparam int H_C = 2;
    localparam int G_C = 1;
    localparam int C_C = 4;
    localparam int L_C = 20;

    logic       CLK;
    logic       RST;
    logic       RS;
    logic       E;
    logic [3:0] dout;

    lcd_nibble_writer_if bus ();

    lcd_nibble_writer dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus),
        .RS   (RS),
        .E    (E),
        .dout (dout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] din;
        logic       rs;
        logic       nib;
        int         rk;     // cycle index Tk at which ready returns
        int         np;     // number of E pulses
        logic [7:0] nibs;   // nibble values seen on E rises, oldest in [7:4]
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Offer one byte while idle; it is accepted at the next rising edge (T0),
    // after which the inputs are scrambled to prove they were latched.
    task automatic send(input logic [7:0] d, input logic r, input logic n);
        bus.din         = d;
        bus.rs_in       = r;
        bus.nibble_only = n;
        bus.valid       = 1'b1;
        @(posedge CLK);
        #1;
        bus.valid       = 1'b0;
        bus.din         = ~d;
        bus.rs_in       = ~r;
        bus.nibble_only = ~n;
    endtask

    // Watch cycles T1.. on falling edges until ready returns.
    // bad counts: RS off its expected value, dout/RS moving while E is or was
    // high, busy not the inverse of ready, E pulses of the wrong width.
    task automatic observe(input int budget, input int poke_k, input logic exp_rs,
                           output int rdy_k, output int npul, output logic [47:0] nibs,
                           output int rise0, output int bad);
        logic       pe;
        logic [3:0] pd;
        logic       prs;
        int         elen;
        rdy_k = -1; npul = 0; nibs = 48'h0; rise0 = -1; bad = 0; elen = 0;
        pe = E; pd = dout; prs = RS;
        for (int k = 1; k <= budget; k++) begin
            @(negedge CLK);
            if ((poke_k > 0) && (k == poke_k)) begin
                bus.valid = 1'b1; bus.din = 8'hFF; bus.rs_in = ~exp_rs; bus.nibble_only = 1'b0;
            end else if ((poke_k > 0) && (k == poke_k + 1)) begin
                bus.valid = 1'b0;
            end
            if (bus.busy == bus.ready) bad++;
            if (RS != exp_rs) bad++;
            if ((E || pe) && ((dout != pd) || (RS != prs))) bad++;
            if (E && !pe) begin
                nibs = {nibs[43:0], dout};
                npul++;
                if (rise0 < 0) rise0 = k;
                elen = 1;
            end else if (E) begin
                elen++;
            end else if (pe && (elen != H_C)) begin
                bad++;
            end
            pe = E; pd = dout; prs = RS;
            if (bus.ready) begin
                rdy_k = k;
                break;
            end
        end
    endtask

    initial begin
        int          rk, np, er, bad;
        logic [47:0] nb;
        logic [7:0]  d;
        logic        r, n, lw;
        int          exp_rk;

        vecs[0] = '{8'h41, 1'b1, 1'b0, 12, 2, 8'h41};
        vecs[1] = '{8'h01, 1'b0, 1'b0, 28, 2, 8'h01};
        vecs[2] = '{8'h0C, 1'b0, 1'b0, 12, 2, 8'h0C};
        vecs[3] = '{8'h30, 1'b0, 1'b1,  8, 1, 8'h03};
        vecs[4] = '{8'h02, 1'b1, 1'b0, 12, 2, 8'h02};
        vecs[5] = '{8'h03, 1'b0, 1'b1,  8, 1, 8'h00};
        vecs[6] = '{8'h02, 1'b0, 1'b0, 28, 2, 8'h02};
        vecs[7] = '{8'h04, 1'b0, 1'b0, 12, 2, 8'h04};
        vecs[8] = '{8'h00, 1'b0, 1'b0, 12, 2, 8'h00};

        RST = 1'b1;
        bus.din = 8'h00; bus.rs_in = 1'b0; bus.nibble_only = 1'b0; bus.valid = 1'b0;
        #12;
        chk("reset_E", E, 0);
        chk("reset_RS", RS, 0);
        chk("reset_dout", dout, 0);
        @(negedge CLK);
        RST = 1'b0;

`ifdef LCD_AUTO_INIT_EN
        observe(2000, 5, 1'b0, rk, np, nb, er, bad);
        chk("init_pulses", np, 12);
        chk("init_nibbles", nb, 48'h3332280C0106);
        chk("init_glitch", bad, 0);
        chk("init_ready_seen", (rk > 0) ? 1 : 0, 1);
`else
        @(negedge CLK);
        chk("idle_ready", bus.ready, 1);
        chk("idle_busy", bus.busy, 0);
`endif

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].din, vecs[i].rs, vecs[i].nib);
            observe(60, 3, vecs[i].rs, rk, np, nb, er, bad);
            chk($sformatf("vec%0d_ready_k", i), rk, vecs[i].rk);
            chk($sformatf("vec%0d_pulses", i), np, vecs[i].np);
            chk($sformatf("vec%0d_nibbles", i), nb[7:0], vecs[i].nibs);
            chk($sformatf("vec%0d_first_e", i), er, 2);
            chk($sformatf("vec%0d_glitch", i), bad, 0);
        end

        // Randomized bytes against the timing/nibble model.
        for (int i = 0; i < 24; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            r = 1'($urandom);
            n = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            lw = !n && !r && (d >= 8'h01) && (d <= 8'h03);
            exp_rk = n ? (S_C + H_C + C_C + 1)
                       : (2 * S_C + 2 * H_C + G_C + (lw ? L_C : C_C) + 1);
            send(d, r, n);
            observe(60, 4, r, rk, np, nb, er, bad);
            chk($sformatf("rnd%0d_ready_k", i), rk, exp_rk);
            chk($sformatf("rnd%0d_pulses", i), np, n ? 1 : 2);
            chk($sformatf("rnd%0d_nibbles", i), nb[7:0], n ? {4'h0, d[7:4]} : d);
            chk($sformatf("rnd%0d_glitch", i), bad, 0);
        end

        // Back-to-back: valid held high, second byte waits for the T12 edge.
        bus.din = 8'h48; bus.rs_in = 1'b1; bus.nibble_only = 1'b0; bus.valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.din = 8'h69;
        observe(40, 0, 1'b1, rk, np, nb, er, bad);
        chk("b2b_first_ready_k", rk, 12);
        chk("b2b_first_nibbles", nb[7:0], 8'h48);
        chk("b2b_first_glitch", bad, 0);
        @(posedge CLK);
        #1;
        bus.valid = 1'b0;
        chk("b2b_second_taken", bus.ready, 0);
        observe(40, 0, 1'b1, rk, np, nb, er, bad);
        chk("b2b_second_ready_k", rk, 12);
        chk("b2b_second_first_e", er, 2);
        chk("b2b_second_nibbles", nb[7:0], 8'h69);
        chk("b2b_second_glitch", bad, 0);

        // Reset in the middle of the high-nibble enable pulse.
        send(8'h41, 1'b1, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_pre_E", E, 1);
        chk("rst_pre_dout", dout, 4'h4);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_async_E", E, 0);
        chk("rst_async_ready", bus.ready, 1);
        chk("rst_async_busy", bus.busy, 0);
        chk("rst_async_RS", RS, 0);
        chk("rst_async_dout", dout, 0);
        @(negedge CLK);
        RST = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (E || !bus.ready) bad++;
        end
        chk("rst_release_quiet", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
